// File: rtl/uart_pkg.sv
// Shared UART definitions: frame/byte state encodings, frame defaults
// and baud constants used by uart_tx, uart_rx and the frame arbiter.
package uart_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'h55;
    localparam logic [3:0] HDR_TAG_DEF   = 4'hA;
    localparam int         LAUNCH_TO_DEF = 16;

    localparam int CLK_HZ  = 50_000_000;
    localparam int BAUD    = 115_200;
    localparam int BPS_CNT = CLK_HZ / BAUD;

    typedef enum logic [2:0] {
        F_IDLE,
        F_ARB,
        F_SYNC,
        F_HDR,
        F_LEN,
        F_PAY,
        F_CHK
    } frame_state_t;

    typedef enum logic [1:0] {
        B_LOAD,
        B_HI,
        B_LO
    } byte_state_t;

    // First set bit of req at or after ptr+1, wrapping modulo n.
    function automatic logic [2:0] rr_pick(
        input logic [7:0] req,
        input logic [2:0] ptr,
        input int         n
    );
        logic [2:0] p;
        logic [7:0] sh;
        int         idx;
        p = ptr;
        for (int k = n; k >= 1; k--) begin
            idx = (int'(ptr) + k) % n;
            sh  = req >> idx;
            if (sh[0]) begin
                p = 3'(idx);
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/uart_byte_launch.sv
// One-byte handshake with uart_tx: strobe when idle, wait for busy to
// rise (bounded by a launch timeout), then wait for it to fall.
module uart_byte_launch
    import uart_pkg::*;
#(
    parameter int LAUNCH_TO = LAUNCH_TO_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] byte_val,
    input  logic       tx_busy,
    output logic [7:0] tx_data,
    output logic       tx_pluse,
    output logic       launched,
    output logic       done,
    output logic       timeout
);

    localparam logic [15:0] LIM = 16'(LAUNCH_TO - 1);

    byte_state_t state;
    byte_state_t state_nx;
    logic [15:0] cnt;
    logic [7:0]  held;
    logic        fire;
    logic        hi_expired;

    assign fire       = (state == B_LOAD) && start && !tx_busy;
    assign hi_expired = (state == B_HI) && !tx_busy && (cnt == LIM);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= B_LOAD;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            B_LOAD: if (fire) state_nx = B_HI;
            B_HI: begin
                if (tx_busy) begin
                    state_nx = B_LO;
                end else if (hi_expired) begin
                    state_nx = B_LOAD;
                end
            end
            B_LO: if (!tx_busy) state_nx = B_LOAD;
            default: state_nx = B_LOAD;
        endcase
    end

    always_comb begin
        tx_pluse = fire;
        launched = fire;
        tx_data  = fire ? byte_val : held;
        timeout  = hi_expired;
        done     = hi_expired || ((state == B_LO) && !tx_busy);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            held <= '0;
        end else begin
            if (state == B_HI) begin
                cnt <= cnt + 16'd1;
            end else begin
                cnt <= '0;
            end
            if (fire) begin
                held <= byte_val;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin frame scheduler in front of uart_tx: wraps each granted
// payload as SYNC, HDR, LEN, payload, CHK.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int         N_REQ     = 2,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
    parameter logic [3:0] HDR_TAG   = HDR_TAG_DEF,
    parameter int         LAUNCH_TO = LAUNCH_TO_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*8-1:0] req_len,
    input  logic [N_REQ*8-1:0] req_data,
    output logic [N_REQ-1:0]   req_rd,
    output logic [N_REQ-1:0]   grant,
    output logic               frame_done,
    output logic               busy,
    output logic               err_timeout,
    output logic [7:0]         tx_data,
    output logic               tx_pluse,
    input  logic               tx_busy
);

    frame_state_t state;
    frame_state_t state_nx;

    logic [N_REQ-1:0]   own;
    logic [2:0]         id;
    logic [2:0]         ptr;
    logic [2:0]         pick_id;
    logic [7:0]         len;
    logic [7:0]         cnt;
    logic [7:0]         chk;
    logic               err;
    logic               fdone;
    logic [N_REQ*8-1:0] len_sh;
    logic [N_REQ*8-1:0] dat_sh;
    logic [7:0]         cur_byte;
    logic               start;
    logic               launched;
    logic               done;
    logic               timeout;

    assign pick_id = rr_pick(8'(req), ptr, N_REQ);
    assign len_sh  = req_len >> {pick_id, 3'b000};
    assign dat_sh  = req_data >> {id, 3'b000};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= F_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            F_IDLE: if (|req) state_nx = F_ARB;
            F_ARB:  state_nx = F_SYNC;
            F_SYNC: if (done) state_nx = F_HDR;
            F_HDR:  if (done) state_nx = F_LEN;
            F_LEN: begin
                if (done) begin
                    state_nx = (len != 8'd0) ? F_PAY : F_CHK;
                end
            end
            F_PAY: if (done && cnt == len) state_nx = F_CHK;
            F_CHK: if (done) state_nx = F_IDLE;
            default: state_nx = F_IDLE;
        endcase
    end

    always_comb begin
        start    = 1'b0;
        cur_byte = SYNC_BYTE;
        req_rd   = '0;
        unique case (state)
            F_SYNC: begin
                start    = 1'b1;
                cur_byte = SYNC_BYTE;
            end
            F_HDR: begin
                start    = 1'b1;
                cur_byte = {HDR_TAG, 1'b0, id};
            end
            F_LEN: begin
                start    = 1'b1;
                cur_byte = len;
            end
            F_PAY: begin
                start    = 1'b1;
                cur_byte = dat_sh[7:0];
                if (launched) begin
                    req_rd = N_REQ'(1) << id;
                end
            end
            F_CHK: begin
                start    = 1'b1;
                cur_byte = chk;
            end
            default: ;
        endcase
    end

    assign busy        = (state != F_IDLE);
    assign grant       = own;
    assign frame_done  = fdone;
    assign err_timeout = err;

    // Owner, length and pointer are captured as IDLE hands over to ARB,
    // so grant is visible during the ARB cycle itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            own   <= '0;
            id    <= '0;
            ptr   <= 3'(N_REQ - 1);
            len   <= '0;
            cnt   <= '0;
            chk   <= '0;
            err   <= 1'b0;
            fdone <= 1'b0;
        end else begin
            fdone <= (state == F_CHK) && done;
            if (timeout) begin
                err <= 1'b1;
            end
            if (state == F_IDLE && |req) begin
                own <= N_REQ'(1) << pick_id;
                id  <= pick_id;
                ptr <= pick_id;
                len <= len_sh[7:0];
            end
            if (state == F_ARB) begin
                chk <= '0;
                cnt <= '0;
            end
            if (launched && (state == F_HDR || state == F_LEN
                             || state == F_PAY)) begin
                chk <= chk ^ cur_byte;
            end
            if (launched && state == F_PAY) begin
                cnt <= cnt + 8'd1;
            end
            if (state == F_CHK && done) begin
                own <= '0;
            end
        end
    end

    uart_byte_launch #(
        .LAUNCH_TO(LAUNCH_TO)
    ) u_launch (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .byte_val (cur_byte),
        .tx_busy  (tx_busy),
        .tx_data  (tx_data),
        .tx_pluse (tx_pluse),
        .launched (launched),
        .done     (done),
        .timeout  (timeout)
    );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: frame-level byte model with a uart_tx busy
// model, plus literal expectations for each directed scenario.
module tb_uart_tx_arbiter;

    localparam int N = 2;
    localparam int LTO = 16;

    typedef logic [7:0] byte_q_t [$];
    typedef struct {
        logic [7:0] b;
        int         kind;
        int         id;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*8-1:0] req_len;
    logic [N*8-1:0] req_data;
    logic [N-1:0]   req_rd;
    logic [N-1:0]   grant;
    logic           frame_done;
    logic           busy;
    logic           err_timeout;
    logic [7:0]     tx_data;
    logic           tx_pluse;
    logic           tx_busy;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] pay [N][256];
    int         rd_idx [N];
    int         mdl_idx [N];
    int         rd_total [N];
    int         bcnt;
    int         busy_cyc;
    logic       tie0;
    int         cyc = 0;
    int         prev_cyc = 0;
    int         done_cnt = 0;
    int         done_pending = 0;
    exp_t       exp_q [$];
    byte_q_t    act_log;
    byte_q_t    gr_log;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N_REQ     (N),
        .SYNC_BYTE (8'h55),
        .HDR_TAG   (4'hA),
        .LAUNCH_TO (LTO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_len     (req_len),
        .req_data    (req_data),
        .req_rd      (req_rd),
        .grant       (grant),
        .frame_done  (frame_done),
        .busy        (busy),
        .err_timeout (err_timeout),
        .tx_data     (tx_data),
        .tx_pluse    (tx_pluse),
        .tx_busy     (tx_busy)
    );

    // uart_tx stand-in: busy for busy_cyc cycles after each strobe.
    always @(posedge clk) begin
        if (rst) begin
            bcnt <= 0;
        end else if (tx_pluse && !tie0) begin
            bcnt <= busy_cyc;
        end else if (bcnt > 0) begin
            bcnt <= bcnt - 1;
        end
    end
    assign tx_busy = (bcnt != 0);

    // First-word-fall-through requesters.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                rd_idx[i] <= 0;
            end else if (req_rd[i]) begin
                rd_idx[i] <= rd_idx[i] + 1;
            end
        end
    end
    always_comb begin
        req_data = '0;
        for (int i = 0; i < N; i++) begin
            req_data[i*8 +: 8] = pay[i][rd_idx[i] % 256];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
        end
    endtask

    task automatic push_frame(input int i, input int n);
        logic [7:0] c;
        logic [7:0] h;
        logic [7:0] b;
        h = {4'hA, 4'(i)};
        exp_q.push_back('{8'h55, 0, i});
        exp_q.push_back('{h, 1, i});
        exp_q.push_back('{8'(n), 1, i});
        c = h ^ 8'(n);
        for (int k = 0; k < n; k++) begin
            b = pay[i][mdl_idx[i] + k];
            c = c ^ b;
            exp_q.push_back('{b, 2, i});
        end
        mdl_idx[i] += n;
        exp_q.push_back('{c, 3, i});
    endtask

    task automatic check_q(input string nm, input byte_q_t act,
                           input byte_q_t lit);
        chk({nm, "_count"}, act.size(), lit.size());
        for (int i = 0; i < lit.size() && i < act.size(); i++) begin
            chk(nm, act[i], lit[i]);
        end
    endtask

    task automatic wait_frames(input int target, input int budget);
        int c;
        c = 0;
        while (done_cnt < target && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk("frame_wait", 32'(done_cnt >= target), 1);
    endtask

    task automatic wait_grant(input int budget);
        int c;
        c = 0;
        while (grant == '0 && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk("grant_wait", 32'(grant != '0), 1);
    endtask

    // Frame-level compare: every strobe must be the next modelled byte.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst) begin
            if (tx_pluse) begin
                act_log.push_back(tx_data);
                chk("pluse_while_busy", 32'(tx_busy), 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind == 0) gr_log.push_back(8'(grant));
                    if (tie0 && e.kind != 0) begin
                        chk("timeout_gap", cyc - prev_cyc, LTO + 1);
                    end
                    chk("tx_data", tx_data, e.b);
                    chk("grant", 32'(grant), 32'(1 << e.id));
                    chk("req_rd", 32'(req_rd),
                        (e.kind == 2) ? 32'(1 << e.id) : 0);
                    if (e.kind == 3) done_pending++;
                end
                prev_cyc = cyc;
                for (int i = 0; i < N; i++) begin
                    if (req_rd[i]) rd_total[i]++;
                end
            end else if (req_rd != '0) begin
                chk("stray_req_rd", 32'(req_rd), 0);
            end
            if (frame_done) begin
                chk("frame_done_expected", 32'(done_pending > 0), 1);
                if (done_pending > 0) done_pending--;
                done_cnt++;
            end
        end
    end

    initial begin
        byte_q_t lit;
        int base;
        rst = 1'b1;
        req = '0;
        req_len = '0;
        tie0 = 1'b0;
        busy_cyc = 434;
        for (int i = 0; i < N; i++) begin
            mdl_idx[i] = 0;
            rd_total[i] = 0;
            for (int k = 0; k < 256; k++) begin
                pay[i][k] = 8'(k * 13 + i * 100 + 7);
            end
        end
        repeat (3) @(negedge clk);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_pluse", 32'(tx_pluse), 0);
        chk("rst_done", 32'(frame_done), 0);
        chk("rst_err", 32'(err_timeout), 0);
        chk("rst_req_rd", 32'(req_rd), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        rst = 1'b0;
        @(negedge clk);

        // Requester 0, three payload bytes, realistic uart busy time.
        pay[0][0] = 8'h11;
        pay[0][1] = 8'h22;
        pay[0][2] = 8'h33;
        req_len[7:0] = 8'd3;
        act_log.delete();
        push_frame(0, 3);
        req = 2'b01;
        @(negedge clk);
        chk("lat_grant", 32'(grant), 32'h1);
        chk("lat_busy", 32'(busy), 1);
        chk("lat_no_pluse_yet", 32'(tx_pluse), 0);
        @(negedge clk);
        chk("lat_first_pluse", 32'(tx_pluse), 1);
        chk("lat_sync", 32'(tx_data), 32'h55);
        req = '0;
        wait_frames(1, 5000);
        lit = '{8'h55, 8'hA0, 8'h03, 8'h11, 8'h22, 8'h33, 8'hA3};
        check_q("t1_bytes", act_log, lit);
        chk("t1_rd_count", rd_total[0], 3);
        chk("t1_no_err", 32'(err_timeout), 0);

        // Zero-length frame from requester 1.
        busy_cyc = 20;
        act_log.delete();
        req_len[15:8] = 8'd0;
        rd_total[1] = 0;
        push_frame(1, 0);
        req = 2'b10;
        wait_grant(20);
        req = '0;
        wait_frames(2, 2000);
        lit = '{8'h55, 8'hA1, 8'h00, 8'hA1};
        check_q("t2_bytes", act_log, lit);
        chk("t2_rd_count", rd_total[1], 0);

        // Both request continuously: grants must alternate.
        req_len = {8'd2, 8'd1};
        gr_log.delete();
        push_frame(0, 1);
        push_frame(1, 2);
        push_frame(0, 1);
        push_frame(1, 2);
        base = done_cnt;
        req = 2'b11;
        wait_frames(base + 3, 3000);
        wait_grant(20);
        req = '0;
        wait_frames(base + 4, 1000);
        lit = '{8'h01, 8'h02, 8'h01, 8'h02};
        check_q("t3_grant_order", gr_log, lit);

        // Transmitter never raises busy: every byte times out.
        tie0 = 1'b1;
        act_log.delete();
        req_len[7:0] = 8'd1;
        pay[0][mdl_idx[0]] = 8'h5A;
        push_frame(0, 1);
        base = done_cnt;
        req = 2'b01;
        wait_grant(20);
        req = '0;
        wait_frames(base + 1, 400);
        chk("t4_err", 32'(err_timeout), 1);
        lit = '{8'h55, 8'hA0, 8'h01, 8'h5A, 8'hFB};
        check_q("t4_bytes", act_log, lit);
        repeat (50) @(negedge clk);
        chk("t4_err_sticky", 32'(err_timeout), 1);
        tie0 = 1'b0;

        // Reset during the second payload byte of a five-byte frame.
        rd_total[0] = 0;
        req_len[7:0] = 8'd5;
        push_frame(0, 5);
        req = 2'b01;
        wait_grant(20);
        req = 2'b11;
        base = 0;
        while (rd_total[0] < 2 && base < 1000) begin
            @(negedge clk);
            base++;
        end
        chk("t5_reach_pay2", rd_total[0], 2);
        base = done_cnt;
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        done_pending = 0;
        @(negedge clk);
        chk("t5_pluse_abort", 32'(tx_pluse), 0);
        chk("t5_grant_abort", 32'(grant), 0);
        chk("t5_busy_abort", 32'(busy), 0);
        chk("t5_rd_abort", 32'(req_rd), 0);
        chk("t5_err_cleared", 32'(err_timeout), 0);
        chk("t5_no_done", done_cnt, base);
        rst = 1'b0;
        mdl_idx[0] = 0;
        mdl_idx[1] = 0;
        req_len = {8'd1, 8'd1};
        gr_log.delete();
        push_frame(0, 1);
        push_frame(1, 1);
        wait_frames(base + 1, 1000);
        wait_grant(20);
        req = '0;
        wait_frames(base + 2, 1000);
        lit = '{8'h01, 8'h02};
        check_q("t5_grant_after_rst", gr_log, lit);

        // Length change after grant is ignored.
        rd_total[0] = 0;
        req_len[7:0] = 8'd3;
        push_frame(0, 3);
        base = done_cnt;
        req = 2'b01;
        wait_grant(20);
        req_len[7:0] = 8'd9;
        req = '0;
        wait_frames(base + 1, 1000);
        chk("t6_rd_count", rd_total[0], 3);
        chk("t6_queue_drained", exp_q.size(), 0);

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Packet-level scheduler that shares the single uart_tx byte transmitter between N_REQ on-chip requesters, e.g. FFT/FIR result streamer and status reporter.
- Wraps each granted payload in a frame: SYNC, HDR, LEN, payload, CHK.
- Drives the transmitter through its tx_data/tx_pluse/tx_busy handshake.
- Replaces the fixed-message generator at the transmitter input.

Parameters:
- N_REQ, 2: number of requesters (1..8).
- SYNC_BYTE, 8'h55: first byte of every frame.
- HDR_TAG, 4'hA: upper nibble of the header byte.
- LAUNCH_TO, 16: cycles to wait for tx_busy to rise after a tx_pluse before declaring a launch timeout.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- req  in  N_REQ  per-requester frame request, level.
- req_len  in  N_REQ*8  payload length for requester i, bits [8i+7:8i].
- req_data  in  N_REQ*8  current payload byte for requester i, first-word-fall-through.
- req_rd  out  N_REQ  one-cycle pulse: requester i's current byte consumed; present the next byte by the following cycle.
- grant  out  N_REQ  one-hot owner of the current frame.
- frame_done  out  1  one-cycle pulse when CHK byte transmission completes.
- busy  out  1  high from ARB through the end of the frame.
- err_timeout  out  1  sticky launch-timeout flag; cleared only by rst.
- tx_data  out  8  byte to transmitter.
- tx_pluse  out  1  one-cycle transmit strobe.
- tx_busy  in  1  transmitter busy.

Behaviour:
- Reset: all outputs are 0; RR pointer = N_REQ-1, so requester 0 has first priority.
- rst mid-frame aborts immediately: tx_pluse = 0 on the next edge, no req_rd or frame_done.
- Frame FSM states:
  - IDLE: if any req bit is set, go to ARB.
  - ARB, 1 cycle: pick the first set req at or after ptr+1 (mod N_REQ). Latch grant, len and id; set ptr = id; clear chk; go to SYNC.
  - SYNC, HDR, LEN, PAY, CHK: send one byte each; PAY repeats len times.
  - LEN to PAY when len != 0; LEN to CHK when len == 0.
  - CHK complete: pulse frame_done, drop grant/busy, go to IDLE.
  - IDLE re-evaluates req on the next cycle; there are no idle gaps beyond that 1 cycle.
- Byte values:
  - HDR = {HDR_TAG, id[3:0]}.
  - LEN = latched len.
  - CHK = XOR of HDR, LEN and all payload bytes; SYNC is excluded.
- Byte sub-FSM, used once per byte:
  - B_LOAD: when tx_busy = 0, assert tx_pluse with tx_data valid that cycle; go to B_HI. For a PAY byte, req_rd[id] pulses the same cycle.
  - B_HI: wait for tx_busy = 1, then go to B_LO. If LAUNCH_TO cycles elapse without it, set err_timeout and treat the byte as sent.
  - B_LO: wait for tx_busy = 0, then advance to the next byte.
- tx_data holds its value from B_LOAD until the next B_LOAD.
- Latency: req rises in IDLE at cycle n → grant at n+1 → first tx_pluse (SYNC) at n+2 if tx_busy = 0.
- Requests and lengths:
  - req deasserted mid-frame is ignored; the frame completes with the latched len.
  - req_len changes after ARB are ignored.
  - Simultaneous requests are resolved by round robin; a continuously asserting requester cannot starve the others.
- Widths: len is 8 bits (0..255 payload bytes); byte counter is 8 bits and does not wrap.

Decomposition:
- Shared package uart_pkg holds:
  - frame state enum, byte sub-state enum;
  - SYNC_BYTE / HDR_TAG defaults;
  - BPS constants shared with uart_tx/uart_rx.
- One sub-module, uart_byte_launch: the B_LOAD/B_HI/B_LO handshake with the timeout counter.
  - Inputs: start, byte.
  - Outputs: tx_data, tx_pluse, launched, done, timeout.
- The arbiter/frame FSM sits in the top.

Test Plan:
- Frame from requester 0 (req0, len 3, data 11 22 33; uart_tx model busy 434 cycles per byte) → bytes 55 A0 03 11 22 33 A3; three req_rd[0] pulses; one frame_done.
- Zero-length frame (req1, len 0) → 55 A1 00 A1; no req_rd pulses.
- Arbitration (req0 and req1 rise the same cycle and stay high) → grants alternate 0,1,0,1 across four frames; no tx_pluse while tx_busy = 1.
- Launch timeout (tx_busy tied 0, req0 len 1) → each byte advances after LAUNCH_TO cycles; err_timeout = 1 and stays set; frame_done still pulses.
- Reset during the PAY byte 2 of len 5 → next cycle tx_pluse = 0 and grant = 0; after release with req1 pending, requester 1 is granted? No: after reset the pointer returns to N_REQ-1, so requester 0 is granted first if both request.
- Length change mid-frame (req_len0 changed 3→9 after grant) → exactly 3 payload bytes sent.
